// File: rtl/neuron_mac_seq.sv
// Sequential single-neuron MAC: out = bias + sum(a[i] * W[i]) in IEEE-754 single, strict order.
// Define NEURON_RELU_EN to clamp negative results to +0.
module neuron_mac_seq #(
  parameter int unsigned N_IN  = 15,
  parameter int unsigned IDX_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             w_we,
  input  logic [IDX_W-1:0] w_addr,
  input  logic [31:0]      w_data,
  input  logic             b_we,
  input  logic [31:0]      b_data,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [31:0] QNan = 32'h7fc00000;

  // Round-to-nearest-even multiply; denormal inputs and underflow flush to signed zero.
  function automatic logic [31:0] float_mult(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [47:0]       p;
    logic [24:0]       m;
    logic              rnd;
    logic              stk;
    logic signed [9:0] e;
    s = a[31] ^ b[31];
    if ((a[30:23] == 8'hff && a[22:0] != 23'h0) || (b[30:23] == 8'hff && b[22:0] != 23'h0)) begin
      return QNan;
    end
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) begin
      if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return QNan;
      return {s, 8'hff, 23'h0};
    end
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m   = {1'b0, p[47:24]};
      rnd = p[23];
      stk = |p[22:0];
      e   = e + 10'sd1;
    end else begin
      m   = {1'b0, p[46:23]};
      rnd = p[22];
      stk = |p[21:0];
    end
    if (rnd && (stk || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {s, 8'hff, 23'h0};
    if (e <= 10'sd0) return {s, 31'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  // Round-to-nearest-even add with guard/round/sticky; denormals treated as zero.
  function automatic logic [31:0] float_adder(input logic [31:0] x, input logic [31:0] y);
    logic [31:0]       a;
    logic [31:0]       b;
    logic [53:0]       sh;
    logic [26:0]       ma;
    logic [26:0]       mb;
    logic [27:0]       sum;
    logic [24:0]       m;
    logic [7:0]        d;
    logic signed [9:0] e;
    if ((x[30:23] == 8'hff && x[22:0] != 23'h0) || (y[30:23] == 8'hff && y[22:0] != 23'h0)) begin
      return QNan;
    end
    if (x[30:23] == 8'hff && y[30:23] == 8'hff && x[31] != y[31]) return QNan;
    if (x[30:23] == 8'hff) return x;
    if (y[30:23] == 8'hff) return y;
    if (y[30:23] == 8'h00) return (x[30:23] == 8'h00) ? {x[31] & y[31], 31'h0} : x;
    if (x[30:23] == 8'h00) return y;
    if (x[30:0] >= y[30:0]) begin
      a = x;
      b = y;
    end else begin
      a = y;
      b = x;
    end
    d  = a[30:23] - b[30:23];
    ma = {1'b1, a[22:0], 3'b000};
    sh = {1'b1, b[22:0], 3'b000, 27'h0} >> d;
    // Bits shifted out of the smaller operand collapse into its sticky LSB.
    if (d > 8'd26) mb = 27'd1;
    else mb = {sh[53:28], sh[27] | (|sh[26:0])};
    e = $signed({2'b00, a[30:23]});
    if (a[31] == b[31]) sum = {1'b0, ma} + {1'b0, mb};
    else sum = {1'b0, ma} - {1'b0, mb};
    if (sum == 28'd0) return 32'h0;
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 10'sd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!sum[26]) begin
          sum = sum << 1;
          e   = e - 10'sd1;
        end
      end
    end
    m = {1'b0, sum[26:3]};
    if (sum[2] && ((|sum[1:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {a[31], 8'hff, 23'h0};
    if (e <= 10'sd0) return {a[31], 31'h0};
    return {a[31], e[7:0], m[22:0]};
  endfunction

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      bias_q, bias_d;
  logic [31:0]      w_q [N_IN];
  logic [31:0]      w_d [N_IN];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             a_ready_q, a_ready_d;
  logic             busy_q, busy_d;
  // Pre-write copy of a weight overwritten on the start edge, so that run still sees the old value.
  logic             hold_q, hold_d;
  logic [IDX_W-1:0] hold_idx_q, hold_idx_d;
  logic [31:0]      hold_w_q, hold_w_d;

  logic             w_hit;
  logic [31:0]      w_cur;
  logic [31:0]      acc_next;
  logic [31:0]      result;

  assign w_hit    = w_we && (32'(w_addr) < N_IN);
  assign w_cur    = (hold_q && hold_idx_q == idx_q) ? hold_w_q : w_q[idx_q];
  assign acc_next = float_adder(acc_q, float_mult(a_data, w_cur));

`ifdef NEURON_RELU_EN
  assign result = acc_next[31] ? 32'h0 : acc_next;
`else
  assign result = acc_next;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    bias_d      = bias_q;
    w_d         = w_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    hold_d      = hold_q;
    hold_idx_d  = hold_idx_q;
    hold_w_d    = hold_w_q;
    unique case (state_q)
      StIdle: begin
        if (w_hit) w_d[w_addr] = w_data;
        if (b_we) bias_d = b_data;
        if (start) begin
          state_d    = StAccum;
          acc_d      = bias_q;
          idx_d      = '0;
          hold_d     = w_hit;
          hold_idx_d = w_addr;
          hold_w_d   = w_hit ? w_q[w_addr] : 32'h0;
        end
      end
      StAccum: begin
        if (a_valid) begin
          acc_d = acc_next;
          idx_d = idx_q + IDX_W'(1);
          if (32'(idx_q) == N_IN - 1) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            out_data_d  = result;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          out_data_d  = 32'h0;
          hold_d      = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    a_ready_d = (state_d == StAccum);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= 32'h0;
      bias_q      <= 32'h0;
      for (int i = 0; i < int'(N_IN); i++) w_q[i] <= 32'h0;
      idx_q       <= '0;
      out_data_q  <= 32'h0;
      out_valid_q <= 1'b0;
      a_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      hold_q      <= 1'b0;
      hold_idx_q  <= '0;
      hold_w_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      w_q         <= w_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      a_ready_q   <= a_ready_d;
      busy_q      <= busy_d;
      hold_q      <= hold_d;
      hold_idx_q  <= hold_idx_d;
      hold_w_q    <= hold_w_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign a_ready   = a_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq with N_IN=4; inputs change and outputs are sampled on negedge.
module tb_neuron_mac_seq;

  localparam logic [31:0] Zero = 32'h00000000;
  localparam logic [31:0] One  = 32'h3F800000;
  localparam logic [31:0] Two  = 32'h40000000;
  localparam logic [31:0] Half = 32'h3F000000;
  localparam logic [31:0] MOne = 32'hBF800000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic        w_we;
  logic [1:0]  w_addr;
  logic [31:0] w_data;
  logic        b_we;
  logic [31:0] b_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  neuron_mac_seq #(.N_IN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .w_we      (w_we),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_we      (b_we),
    .b_data    (b_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_w(input logic [31:0] w0, w1, w2, w3, input logic [31:0] bias);
    logic [31:0] ws [4];
    ws = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      w_we = 1'b1; w_addr = 2'(i); w_data = ws[i];
      tick();
    end
    w_we = 1'b0;
    b_we = 1'b1; b_data = bias;
    tick();
    b_we = 1'b0;
  endtask

  // Feeds four activations with `gap` idle cycles before each, then checks 1-cycle result latency.
  task automatic feed(input string tag, input logic [31:0] a0, a1, a2, a3, input int gap,
                      input logic [31:0] exp_out);
    logic [31:0] acts [4];
    acts = '{a0, a1, a2, a3};
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
      check_eq({tag, "_ready"}, 32'(a_ready), 32'd1);
      if (i == 3) check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
      a_valid = 1'b1; a_data = acts[i];
      tick();
    end
    a_valid = 1'b0;
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_data"}, out_data, exp_out);
  endtask

  task automatic run_eval(input string tag, input logic [31:0] a0, a1, a2, a3, input int gap,
                          input logic [31:0] exp_out);
    start = 1'b1;
    tick();
    start = 1'b0; w_we = 1'b0; b_we = 1'b0;
    feed(tag, a0, a1, a2, a3, gap, exp_out);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_drain_data"}, out_data, Zero);
    check_eq({tag, "_drain_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; a_data = Zero; a_valid = 1'b0; w_we = 1'b0; w_addr = 2'd0;
    w_data = Zero; b_we = 1'b0; b_data = Zero; out_ready = 1'b0;
    #12;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", out_data, Zero);
    check_eq("rst_ready", 32'(a_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    load_w(One, One, One, One, Zero);
    run_eval("pos", One, Two, Half, Half, 0, 32'h40800000);
    drain("pos");

    load_w(MOne, MOne, MOne, MOne, Zero);
`ifdef NEURON_RELU_EN
    run_eval("neg", One, Two, Half, Half, 0, 32'h00000000);
`else
    run_eval("neg", One, Two, Half, Half, 0, 32'hC0800000);
`endif
    drain("neg");

    load_w(Zero, Zero, Zero, Zero, One);
    run_eval("bias_only", 32'h40400000, 32'hC0000000, 32'h41200000, One, 3, One);
    drain("bias_only");

    load_w(One, One, One, One, One);
    run_eval("gaps", One, Two, Half, Half, 2, 32'h40A00000);
    drain("gaps");

    // Writes and start pulses while busy must be ignored; result held during a 5-cycle stall.
    load_w(One, One, One, One, Zero);
    start = 1'b1; tick();
    a_valid = 1'b1; a_data = One; w_we = 1'b1; w_addr = 2'd0; w_data = Two; start = 1'b1;
    tick();
    w_we = 1'b0; start = 1'b0; a_data = Two; tick();
    a_data = Half; tick();
    a_data = Half; tick();
    a_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0); b_we = 1'b1; b_data = Two;
      check_eq("stall_valid", 32'(out_valid), 32'd1);
      check_eq("stall_data", out_data, 32'h40800000);
      tick();
    end
    start = 1'b0; b_we = 1'b0;
    drain("stall");
    run_eval("unchanged", One, Zero, Zero, Zero, 0, One);
    drain("unchanged");

    // Write on the start edge: this run sees old W0/bias, the next sees the new ones.
    w_we = 1'b1; w_addr = 2'd0; w_data = Two; b_we = 1'b1; b_data = One;
    run_eval("same_edge", One, Two, Half, Half, 0, 32'h40800000);
    drain("same_edge");
    run_eval("after_write", One, One, One, One, 0, 32'h40C00000);

    // Back-to-back with out_ready high: exactly one IDLE cycle between runs.
    out_ready = 1'b1; start = 1'b1;
    tick();
    check_eq("b2b_idle_busy", 32'(busy), 32'd0);
    check_eq("b2b_idle_valid", 32'(out_valid), 32'd0);
    tick();
    start = 1'b0;
    feed("b2b", One, One, One, One, 0, 32'h40C00000);
    tick();
    out_ready = 1'b0;
    check_eq("b2b_done_busy", 32'(busy), 32'd0);

    // Mid-run reset after two accepts.
    start = 1'b1; tick(); start = 1'b0;
    a_valid = 1'b1; a_data = One; tick();
    a_data = Two; tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_data", out_data, Zero);
    check_eq("mid_rst_ready", 32'(a_ready), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("post_rst_valid", 32'(out_valid), 32'd0);
    end
    run_eval("cleared", One, Two, Half, Half, 0, Zero);
    drain("cleared");
    load_w(Two, Two, Two, Two, Zero);
    run_eval("fresh", One, Two, Half, Half, 0, 32'h41000000);
    drain("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
